// File: rtl/simon_lfsr_pkg.sv
// Shared constants for the Simon LFSR family: feedback-mode encodings and the
// default 30-bit tap mask (x^30 + x^6 + x^4 + x + 1).
package simon_lfsr_pkg;

    localparam int LFSR_FIBONACCI = 0;
    localparam int LFSR_GALOIS    = 1;

    localparam logic [29:0] TAPS_30 = 30'h2000_0029;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step. Fibonacci shifts left and appends the tap
// parity; Galois shifts right and folds the tap mask in when the LSB is set.
module lfsr_step
    import simon_lfsr_pkg::*;
#(
    parameter int               WIDTH = 30,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_30),
    parameter int               MODE  = LFSR_FIBONACCI
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    if (MODE == LFSR_GALOIS) begin : g_galois
        assign next = (state >> 1) ^ ({WIDTH{state[0]}} & TAPS);
    end else begin : g_fibonacci
        assign next = {state[WIDTH-2:0], ^(state & TAPS)};
    end

endmodule

// File: rtl/param_lfsr.sv
// Parametrised LFSR: configurable width, taps, seed, feedback mode and steps
// per enabled clock. Supports runtime seed load with zero-seed rejection
// (lockup pulse) and a wrapped pulse when the state returns to its start.
// Optional build macro LFSR_STEP_COUNT_EN adds a saturating step_count output
// that counts enabled cycles since reset, load or the last wrap.
module param_lfsr
    import simon_lfsr_pkg::*;
#(
    parameter int               WIDTH = 30,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_30),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               MODE  = LFSR_FIBONACCI,
    parameter int               STEPS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data,
    output logic             lockup,
`ifdef LFSR_STEP_COUNT_EN
    output logic             wrapped,
    output logic [WIDTH-1:0] step_count
`else
    output logic             wrapped
`endif
);

    // Reject illegal configurations at elaboration time.
    if (SEED == '0) begin : g_bad_seed
        $error("param_lfsr: SEED must be non-zero");
    end
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("param_lfsr: WIDTH must be in 2..64");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("param_lfsr: STEPS must be in 1..WIDTH");
    end

    logic [WIDTH-1:0] start_state;
    logic [WIDTH-1:0] stepped;
    logic             wrap_hit;

    // Chain STEPS single-step stages so one enabled clock advances STEPS states.
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        if (k == 0) begin : g_first
            assign cur = data;
        end else begin : g_next
            assign cur = g_step[k-1].nxt;
        end
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .MODE  (MODE)
        ) u_step (
            .state (cur),
            .next  (nxt)
        );
    end

    assign stepped  = g_step[STEPS-1].nxt;
    // Only the state at the cycle boundary is compared, so intermediate
    // steps landing on start_state do not count as a wrap.
    assign wrap_hit = (stepped == start_state);

    // State, start-state and pulse registers; load outranks enable.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data        <= SEED;
            start_state <= SEED;
            lockup      <= 1'b0;
            wrapped     <= 1'b0;
        end else if (load) begin
            wrapped <= 1'b0;
            if (seed_in != '0) begin
                data        <= seed_in;
                start_state <= seed_in;
                lockup      <= 1'b0;
            end else begin
                // A zero seed would lock the register; fall back to SEED.
                data        <= SEED;
                start_state <= SEED;
                lockup      <= 1'b1;
            end
        end else if (enable) begin
            data    <= stepped;
            lockup  <= 1'b0;
            wrapped <= wrap_hit;
        end else begin
            lockup  <= 1'b0;
            wrapped <= 1'b0;
        end
    end

`ifdef LFSR_STEP_COUNT_EN
    // Saturating count of enabled cycles, cleared by reset, load and wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_count <= '0;
        end else if (load) begin
            step_count <= '0;
        end else if (enable) begin
            if (wrap_hit) begin
                step_count <= '0;
            end else if (step_count != '1) begin
                step_count <= step_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_lfsr.sv
// Self-checking bench for param_lfsr. Four instances (30-bit default,
// 4-bit Fibonacci, 4-bit Galois, 4-bit Fibonacci with STEPS=2) share one
// stimulus stream. The reference model tracks each instance as a position on
// a precomputed orbit of states; the driver pushes expected outputs into a
// scoreboard queue and a monitor pops and compares after every clock edge.
// Honours LFSR_STEP_COUNT_EN when defined.
module tb_param_lfsr;
    import simon_lfsr_pkg::*;

    localparam int NI        = 4;
    localparam int ORBIT_MAX = 4096;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        load;
    logic [29:0] seed_w;
    logic [3:0]  seed_n;

    logic [29:0] data_def;
    logic [3:0]  data_fib, data_gal, data_fib2;
    logic        lockup_def, lockup_fib, lockup_gal, lockup_fib2;
    logic        wrapped_def, wrapped_fib, wrapped_gal, wrapped_fib2;
`ifdef LFSR_STEP_COUNT_EN
    logic [29:0] cnt_def;
    logic [3:0]  cnt_fib, cnt_gal, cnt_fib2;
`endif

    param_lfsr u_def (
        .clock (clock), .reset (reset), .enable (enable), .load (load),
        .seed_in (seed_w), .data (data_def), .lockup (lockup_def),
`ifdef LFSR_STEP_COUNT_EN
        .step_count (cnt_def),
`endif
        .wrapped (wrapped_def)
    );

    param_lfsr #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .MODE(LFSR_FIBONACCI), .STEPS(1)) u_fib (
        .clock (clock), .reset (reset), .enable (enable), .load (load),
        .seed_in (seed_n), .data (data_fib), .lockup (lockup_fib),
`ifdef LFSR_STEP_COUNT_EN
        .step_count (cnt_fib),
`endif
        .wrapped (wrapped_fib)
    );

    param_lfsr #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(LFSR_GALOIS), .STEPS(1)) u_gal (
        .clock (clock), .reset (reset), .enable (enable), .load (load),
        .seed_in (seed_n), .data (data_gal), .lockup (lockup_gal),
`ifdef LFSR_STEP_COUNT_EN
        .step_count (cnt_gal),
`endif
        .wrapped (wrapped_gal)
    );

    param_lfsr #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .MODE(LFSR_FIBONACCI), .STEPS(2)) u_fib2 (
        .clock (clock), .reset (reset), .enable (enable), .load (load),
        .seed_in (seed_n), .data (data_fib2), .lockup (lockup_fib2),
`ifdef LFSR_STEP_COUNT_EN
        .step_count (cnt_fib2),
`endif
        .wrapped (wrapped_fib2)
    );

    // Gather instance outputs into arrays for uniform checking.
    logic [63:0] act_data [NI];
    logic        act_lock [NI];
    logic        act_wrap [NI];
    assign act_data[0] = 64'(data_def);
    assign act_data[1] = 64'(data_fib);
    assign act_data[2] = 64'(data_gal);
    assign act_data[3] = 64'(data_fib2);
    assign act_lock[0] = lockup_def;
    assign act_lock[1] = lockup_fib;
    assign act_lock[2] = lockup_gal;
    assign act_lock[3] = lockup_fib2;
    assign act_wrap[0] = wrapped_def;
    assign act_wrap[1] = wrapped_fib;
    assign act_wrap[2] = wrapped_gal;
    assign act_wrap[3] = wrapped_fib2;
`ifdef LFSR_STEP_COUNT_EN
    logic [63:0] act_cnt [NI];
    assign act_cnt[0] = 64'(cnt_def);
    assign act_cnt[1] = 64'(cnt_fib);
    assign act_cnt[2] = 64'(cnt_gal);
    assign act_cnt[3] = 64'(cnt_fib2);
`endif

    // Instance configurations as seen by the reference model.
    int          cfg_width [NI] = '{30, 4, 4, 4};
    logic [63:0] cfg_taps  [NI] = '{64'h2000_0029, 64'h9, 64'hC, 64'h9};
    int          cfg_mode  [NI] = '{0, 0, 1, 0};
    int          cfg_steps [NI] = '{1, 1, 1, 2};
    logic [63:0] cfg_seed  [NI] = '{64'h1, 64'h1, 64'h1, 64'h1};

    // Expected sequences from the block's documented examples.
    logic [3:0] fib_tab [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] gal_tab [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

    typedef struct {
        logic [63:0] data    [NI];
        logic        lockup  [NI];
        logic        wrapped [NI];
        logic [63:0] cnt     [NI];
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference model state: orbit of states from the current start state,
    // whether the orbit closed, and the position on it.
    logic [63:0] orbit  [NI][$];
    bit          closed [NI];
    int          pos    [NI];
    logic [63:0] cnt    [NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask_of(input int i);
        return (64'(1) << cfg_width[i]) - 64'(1);
    endfunction

    function automatic logic [63:0] ref_step(input int i, input logic [63:0] s);
        if (cfg_mode[i] == 0)
            return ((s << 1) | 64'($countones(s & cfg_taps[i]) % 2)) & mask_of(i);
        else if (s % 2 == 1)
            return (s >> 1) ^ cfg_taps[i];
        else
            return s >> 1;
    endfunction

    task automatic build_orbit(input int i, input logic [63:0] start);
        logic [63:0] s;
        orbit[i].delete();
        s = start;
        do begin
            orbit[i].push_back(s);
            s = ref_step(i, s);
        end while (s != start && orbit[i].size() < ORBIT_MAX);
        closed[i] = (s == start);
        pos[i]    = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            build_orbit(i, cfg_seed[i]);
            cnt[i] = '0;
        end
    endtask

    task automatic model_cycle(input bit en, input bit ld, input logic [63:0] sw,
                               input logic [63:0] sn, output exp_t e);
        for (int i = 0; i < NI; i++) begin
            logic [63:0] sin;
            sin          = (i == 0) ? sw : sn;
            e.lockup[i]  = 1'b0;
            e.wrapped[i] = 1'b0;
            if (ld) begin
                if (sin != 0) begin
                    build_orbit(i, sin);
                end else begin
                    build_orbit(i, cfg_seed[i]);
                    e.lockup[i] = 1'b1;
                end
                cnt[i] = '0;
            end else if (en) begin
                if (closed[i]) begin
                    pos[i]       = (pos[i] + cfg_steps[i]) % orbit[i].size();
                    e.wrapped[i] = (pos[i] == 0);
                end else begin
                    pos[i] = pos[i] + cfg_steps[i];
                end
                if (e.wrapped[i])             cnt[i] = '0;
                else if (cnt[i] != mask_of(i)) cnt[i] = cnt[i] + 1;
            end
            e.data[i] = (pos[i] < orbit[i].size()) ? orbit[i][pos[i]] : 64'hx;
            e.cnt[i]  = cnt[i];
        end
    endtask

    // Drive one clock of stimulus and queue the outcome expected after the edge.
    task automatic cycle(input bit en, input bit ld, input logic [29:0] sw, input logic [3:0] sn);
        exp_t e;
        @(negedge clock);
        enable = en;
        load   = ld;
        seed_w = sw;
        seed_n = sn;
        model_cycle(en, ld, 64'(sw), 64'(sn), e);
        sb.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_data[%0d]", tag, i), act_data[i], cfg_seed[i]);
            check($sformatf("%s_lockup[%0d]", tag, i), 64'(act_lock[i]), 64'(0));
            check($sformatf("%s_wrapped[%0d]", tag, i), 64'(act_wrap[i]), 64'(0));
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: compare every instance against the queued expectation.
    always begin
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int i = 0; i < NI; i++) begin
                check($sformatf("data[%0d]", i), act_data[i], mon_e.data[i]);
                check($sformatf("lockup[%0d]", i), 64'(act_lock[i]), 64'(mon_e.lockup[i]));
                check($sformatf("wrapped[%0d]", i), 64'(act_wrap[i]), 64'(mon_e.wrapped[i]));
`ifdef LFSR_STEP_COUNT_EN
                check($sformatf("step_count[%0d]", i), act_cnt[i], mon_e.cnt[i]);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        seed_w = '0;
        seed_n = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b1;

        // Enable held for one full period of the 4-bit instances.
        for (int k = 0; k < 15; k++) begin
            cycle(1'b1, 1'b0, '0, '0);
            @(posedge clock);
            #2;
            if (k == 0) check("def_first_step", 64'(data_def), 64'h3);
            check($sformatf("fib_seq[%0d]", k), 64'(data_fib), 64'(fib_tab[k]));
            check($sformatf("gal_seq[%0d]", k), 64'(data_gal), 64'(gal_tab[k]));
            check($sformatf("fib_wrap[%0d]", k), 64'(wrapped_fib), 64'(k == 14));
            check($sformatf("fib2_wrap[%0d]", k), 64'(wrapped_fib2), 64'(k == 14));
        end

        // Hold: enable low.
        repeat (10) cycle(1'b0, 1'b0, '0, '0);

        // Load wins over enable, then walk a full period from the new seed.
        cycle(1'b1, 1'b1, 30'h1234_5678, 4'hA);
        repeat (16) cycle(1'b1, 1'b0, '0, '0);

        // Zero seed is rejected with a lockup pulse.
        cycle(1'b1, 1'b1, 30'h0, 4'h0);
        repeat (3) cycle(1'b1, 1'b0, '0, '0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 7) == 0) ? 30'h0 : 30'($urandom),
                  4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-sequence, sampled before the next edge.
        @(negedge clock);
        enable = 1'b1;
        load   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (20) cycle(1'b1, 1'b0, '0, '0);

        repeat (2) @(posedge clock);
        #3;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
